// File: rtl/bch_syndrome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_ctrl
//  Description : Serial BCH syndrome generator over GF(2^13)
//                (primitive polynomial x^13+x^4+x^3+x+1).
//                Received bits arrive highest degree first. Each syndrome
//                S_j = r(alpha^j), j = 1..2T, is evaluated with Horner's rule
//                as S_j <= S_j*alpha^j ^ bit. The frame ends after N accepted
//                bits. Results are held with a valid/ready handshake until
//                the consumer takes them.
//  Ports       :
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_bit     in   received codeword bit (r_(N-1) first, r_0 last)
//    in_valid   in   in_bit valid this cycle
//    in_ready   out  block accepts a bit this cycle (state decode only)
//    abort      in   synchronous frame discard, highest priority
//    syn        out  packed syndromes, S_j at [13j-1 : 13(j-1)]
//    syn_valid  out  syn / no_err valid
//    syn_ready  in   consumer takes the syndromes
//    no_err     out  all syndromes zero (registered, 0 unless syn_valid)
//  Revision    : 1.0  initial release
// ============================================================================
module bch_syndrome_ctrl #(
    parameter int N = 1023,
    parameter int T = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [13*2*T-1:0] syn,
    output logic              syn_valid,
    input  logic              syn_ready,
    output logic              no_err
);

    localparam int          c_NSYN     = 2 * T;
    localparam logic [12:0] c_N_CNT    = 13'(N);
    localparam logic [12:0] c_POLY_LOW = 13'h001B;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Single multiply-by-alpha step: shift, fold x^13 back via the low terms.
    function automatic logic [12:0] mul_alpha(input logic [12:0] a);
        return {a[11:0], 1'b0} ^ (a[12] ? c_POLY_LOW : 13'd0);
    endfunction

    // Chain of `pow` alpha steps; the loop runs to a fixed bound so each
    // instance unrolls into a plain XOR network.
    function automatic logic [12:0] mul_alpha_pow(input logic [12:0] a, input int pow);
        logic [12:0] v;
        v = a;
        for (int k = 0; k < c_NSYN; k++) begin
            if (k < pow) v = mul_alpha(v);
        end
        return v;
    endfunction

    logic [1:0]  r_state;
    logic [12:0] r_cnt;
    logic [12:0] r_syn [c_NSYN];
    logic        r_syn_valid;
    logic        r_no_err;

    logic [12:0] w_syn_next [c_NSYN];
    logic        w_accept;
    logic        w_last;
    logic        w_next_zero;

    generate
        for (genvar j = 0; j < c_NSYN; j++) begin : g_syn
            assign w_syn_next[j] = mul_alpha_pow(r_syn[j], j + 1) ^ {12'd0, in_bit};
            assign syn[13*j +: 13] = r_syn[j];
        end
    endgenerate

    // Zero test on the values being loaded, so no_err can be registered
    // together with the final syndromes.
    always_comb begin
        w_next_zero = 1'b1;
        for (int k = 0; k < c_NSYN; k++) begin
            if (w_syn_next[k] != 13'd0) w_next_zero = 1'b0;
        end
    end

    assign in_ready  = (r_state != c_ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = ((r_cnt + 13'd1) == c_N_CNT);
    assign syn_valid = r_syn_valid;
    assign no_err    = r_no_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 13'd0;
            r_syn_valid <= 1'b0;
            r_no_err    <= 1'b0;
            for (int k = 0; k < c_NSYN; k++) r_syn[k] <= 13'd0;
        end else if (abort) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 13'd0;
            r_syn_valid <= 1'b0;
            r_no_err    <= 1'b0;
            for (int k = 0; k < c_NSYN; k++) r_syn[k] <= 13'd0;
        end else begin
            case (r_state)
                // IDLE holds all-zero syndromes, so the shared Horner update
                // loads S_j = in_bit for the first bit of a frame.
                c_ST_IDLE, c_ST_ACCUM: begin
                    if (w_accept) begin
                        for (int k = 0; k < c_NSYN; k++) r_syn[k] <= w_syn_next[k];
                        r_cnt <= r_cnt + 13'd1;
                        if (w_last) begin
                            r_state     <= c_ST_DONE;
                            r_syn_valid <= 1'b1;
                            r_no_err    <= w_next_zero;
                        end else begin
                            r_state <= c_ST_ACCUM;
                        end
                    end
                end
                c_ST_DONE: begin
                    // in_ready is low here, so no bit of the next frame can
                    // slip in on the release cycle.
                    if (syn_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= 13'd0;
                        r_syn_valid <= 1'b0;
                        r_no_err    <= 1'b0;
                        for (int k = 0; k < c_NSYN; k++) r_syn[k] <= 13'd0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_cnt       <= 13'd0;
                    r_syn_valid <= 1'b0;
                    r_no_err    <= 1'b0;
                    for (int k = 0; k < c_NSYN; k++) r_syn[k] <= 13'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bch_syndrome_ctrl
//  Description : Self-checking bench for bch_syndrome_ctrl. Syndromes are
//                predicted as sums of alpha^(i*j) over the set bits of the
//                received word, using exp/log tables of GF(2^13).
//                Two instances: N=4 for frame control, N=1023 for a real
//                shortened BCH codeword built from its generator polynomial.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bch_syndrome_ctrl;

    localparam int c_T  = 4;
    localparam int c_SW = 13 * 2 * c_T;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            a_in_bit, a_in_valid, a_abort, a_syn_ready;
    logic            a_in_ready, a_syn_valid, a_no_err;
    logic [c_SW-1:0] a_syn;

    logic            b_in_bit, b_in_valid, b_abort, b_syn_ready;
    logic            b_in_ready, b_syn_valid, b_no_err;
    logic [c_SW-1:0] b_syn;

    bch_syndrome_ctrl #(.N(4), .T(c_T)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_bit(a_in_bit), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .abort(a_abort), .syn(a_syn),
        .syn_valid(a_syn_valid), .syn_ready(a_syn_ready), .no_err(a_no_err)
    );

    bch_syndrome_ctrl #(.N(1023), .T(c_T)) u_dut1023 (
        .clk(clk), .rst_n(rst_n), .in_bit(b_in_bit), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .abort(b_abort), .syn(b_syn),
        .syn_valid(b_syn_valid), .syn_ready(b_syn_ready), .no_err(b_no_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] exp_t [0:8190];
    int          log_t [0:8191];
    bit          cw    [0:1022];

    task automatic check(input string tag, input logic [c_SW-1:0] got, input logic [c_SW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
        if (a == 13'd0 || b == 13'd0) return 13'd0;
        return exp_t[(log_t[a] + log_t[b]) % 8191];
    endfunction

    // S_j = XOR of alpha^(i*j) over all set coefficients r_i.
    function automatic logic [c_SW-1:0] model_syn(input int n);
        logic [c_SW-1:0] v;
        logic [12:0]     s;
        v = '0;
        for (int j = 1; j <= 2 * c_T; j++) begin
            s = 13'd0;
            for (int i = 0; i < n; i++) if (cw[i]) s ^= exp_t[(i * j) % 8191];
            v[13*(j-1) +: 13] = s;
        end
        return v;
    endfunction

    function automatic logic [c_SW-1:0] model4(input logic [3:0] bits);
        for (int i = 0; i < 4; i++) cw[i] = bits[i];
        return model_syn(4);
    endfunction

    // Minimal polynomial of alpha^j: product of (x + alpha^(j*2^k)).
    function automatic logic [13:0] min_poly(input int j);
        logic [12:0] p [0:13];
        logic [12:0] r;
        logic [13:0] res;
        for (int i = 0; i < 14; i++) p[i] = 13'd0;
        p[0] = 13'd1;
        for (int k = 0; k < 13; k++) begin
            r = exp_t[(j * (1 << k)) % 8191];
            for (int i = k + 1; i >= 1; i--) p[i] = p[i-1] ^ gmul(p[i], r);
            p[0] = gmul(p[0], r);
        end
        for (int i = 0; i < 14; i++) res[i] = p[i][0];
        return res;
    endfunction

    task automatic frame_a(input logic [3:0] bits, input int gap_pct);
        for (int i = 3; i >= 0; i--) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                a_in_valid = 1'b0;
                a_in_bit   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("in_ready_in_frame", a_in_ready, 1);
            if (i == 0) check("syn_valid_before_last", a_syn_valid, 0);
            a_in_valid = 1'b1;
            a_in_bit   = bits[i];
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        check("syn_valid_latency", a_syn_valid, 1);
    endtask

    task automatic result_a(input logic [3:0] bits);
        logic [c_SW-1:0] m;
        m = model4(bits);
        check("syn", a_syn, m);
        check("no_err", a_no_err, (m == '0));
    endtask

    task automatic stall_a(input logic [3:0] bits, input int cycles);
        logic [c_SW-1:0] m;
        m = model4(bits);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            a_in_valid = 1'($urandom_range(0, 1));
            a_in_bit   = 1'($urandom_range(0, 1));
            check("stall_in_ready", a_in_ready, 0);
            check("stall_syn", a_syn, m);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic release_a();
        @(negedge clk);
        a_syn_ready = 1'b1;
        @(negedge clk);
        a_syn_ready = 1'b0;
        check("idle_syn_valid", a_syn_valid, 0);
        check("idle_in_ready", a_in_ready, 1);
        check("idle_syn", a_syn, '0);
        check("idle_no_err", a_no_err, 0);
    endtask

    task automatic stream_b(input int gap_pct);
        for (int i = 1022; i >= 0; i--) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                b_in_valid = 1'b0;
            end
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_bit   = cw[i];
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        check("b_syn_valid", b_syn_valid, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0]     a;
        logic [3:0]      bits;
        logic [63:0]     g, ng;
        logic [13:0]     mp;
        logic [c_SW-1:0] m;
        int              p;

        rst_n = 1'b0;
        a_in_bit = 0; a_in_valid = 0; a_abort = 0; a_syn_ready = 0;
        b_in_bit = 0; b_in_valid = 0; b_abort = 0; b_syn_ready = 0;

        a = 13'd1;
        for (int k = 0; k < 8191; k++) begin
            exp_t[k] = a;
            log_t[a] = k;
            a = {a[11:0], 1'b0} ^ (a[12] ? 13'h001B : 13'd0);
        end

        #22;
        check("reset_syn", a_syn, '0);
        check("reset_syn_valid", a_syn_valid, 0);
        check("reset_no_err", a_no_err, 0);
        check("reset_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 1,0,0,0 with known constants, then a 10-cycle stall.
        frame_a(4'b1000, 0);
        result_a(4'b1000);
        check("s1_const", a_syn[12:0], 13'h0008);
        check("s2_const", a_syn[25:13], 13'h0040);
        check("s8_const", a_syn[103:91], 13'h185A);
        stall_a(4'b1000, 10);
        release_a();

        // Release cycle with a bit offered: that bit must be ignored.
        frame_a(4'b0001, 0);
        result_a(4'b0001);
        check("all_ones", a_syn, {8{13'h0001}});
        @(negedge clk);
        a_syn_ready = 1'b1; a_in_valid = 1'b1; a_in_bit = 1'b1;
        @(negedge clk);
        a_syn_ready = 1'b0; a_in_valid = 1'b0;
        check("release_syn", a_syn, '0);
        check("release_syn_valid", a_syn_valid, 0);
        frame_a(4'b0000, 30);
        result_a(4'b0000);
        check("zero_no_err", a_no_err, 1);
        release_a();

        // Random frames with gaps and stalls.
        for (int t = 0; t < 8; t++) begin
            bits = 4'($urandom_range(0, 15));
            frame_a(bits, 40);
            result_a(bits);
            stall_a(bits, $urandom_range(0, 10));
            release_a();
        end

        // Abort after two bits; the bit offered with abort is dropped.
        @(negedge clk); a_in_valid = 1'b1; a_in_bit = 1'b1;
        @(negedge clk); a_in_bit = 1'b1;
        @(negedge clk); a_abort = 1'b1; a_in_bit = 1'b1;
        @(negedge clk); a_abort = 1'b0; a_in_valid = 1'b0;
        check("abort_syn", a_syn, '0);
        check("abort_syn_valid", a_syn_valid, 0);
        check("abort_in_ready", a_in_ready, 1);
        frame_a(4'b1000, 20);
        result_a(4'b1000);
        release_a();
        frame_a(4'b0000, 0);
        check("pre_abort_no_err", a_no_err, 1);
        @(negedge clk); a_abort = 1'b1; a_syn_ready = 1'b1;
        @(negedge clk); a_abort = 1'b0; a_syn_ready = 1'b0;
        check("abort_done_syn_valid", a_syn_valid, 0);
        check("abort_done_no_err", a_no_err, 0);
        check("abort_done_in_ready", a_in_ready, 1);

        // Asynchronous reset mid-frame, then in DONE.
        @(negedge clk); a_in_valid = 1'b1; a_in_bit = 1'b1;
        @(negedge clk); a_in_bit = 1'b1;
        @(negedge clk); a_in_valid = 1'b0;
        @(posedge clk); #3; rst_n = 1'b0; #1;
        check("rst_mid_syn", a_syn, '0);
        check("rst_mid_in_ready", a_in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        frame_a(4'b0000, 0);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check("rst_done_syn_valid", a_syn_valid, 0);
        check("rst_done_no_err", a_no_err, 0);
        check("rst_done_in_ready", a_in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        bits = 4'($urandom_range(1, 15));
        frame_a(bits, 25);
        result_a(bits);
        release_a();

        // N=1023: codeword = message * g(x), g = m1*m3*m5*m7.
        g = 64'd1;
        for (int j = 1; j <= 7; j += 2) begin
            mp = min_poly(j);
            ng = 64'd0;
            for (int d = 0; d < 14; d++) if (mp[d]) ng ^= (g << d);
            g = ng;
        end
        for (int i = 0; i < 1023; i++) cw[i] = 1'b0;
        for (int i = 0; i < 1023 - 52; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int d = 0; d <= 52; d++) if (g[d]) cw[i+d] = ~cw[i+d];
            end
        end
        stream_b(20);
        check("cw_no_err", b_no_err, 1);
        check("cw_syn", b_syn, '0);
        @(negedge clk); b_syn_ready = 1'b1;
        @(negedge clk); b_syn_ready = 1'b0;
        check("b_idle_syn_valid", b_syn_valid, 0);

        p = $urandom_range(0, 1022);
        cw[p] = ~cw[p];
        m = model_syn(1023);
        stream_b(20);
        check("err_no_err", b_no_err, 0);
        check("err_s1", b_syn[12:0], exp_t[p]);
        check("err_syn", b_syn, m);
        @(negedge clk); b_syn_ready = 1'b1;
        @(negedge clk); b_syn_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
